// File: rtl/uop_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uop_pkg
// Desc   : Shared micro-op widths, field positions and the NOP encoding.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package uop_pkg;

    localparam int UOP_W     = 20;
    localparam int ENTRY_W   = UOP_W + 1;

    localparam int STORE_BIT = 13;
    localparam int DEST_MSB  = 11;
    localparam int DEST_LSB  = 8;
    localparam int SRC0_MSB  = 2;
    localparam int SRC0_LSB  = 0;
    localparam int SRC1_MSB  = 5;
    localparam int SRC1_LSB  = 3;

    // Dest 4'hF can never equal a zero-extended 3-bit source, so no false hazards.
    localparam logic [UOP_W-1:0] NOP_UOP = 20'h00F00;

    typedef struct packed {
        logic             last;
        logic [UOP_W-1:0] uop;
    } uop_entry_t;

endpackage
`default_nettype wire

// File: rtl/uop_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uop_fifo
// Desc   : One micro-op stream: storage, pointers, head view and last-issued uop.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module uop_fifo #(
    parameter int               DEPTH   = 4,
    parameter int               UOP_W   = 20,
    parameter logic [UOP_W-1:0] NOP_UOP = 20'h00F00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [UOP_W-1:0] push_uop,
    input  logic             push_last,
    input  logic             pop_req,
    output logic             full,
    output logic             valid,
    output logic [UOP_W-1:0] uop_next,
    output logic             uop_is_last,
    output logic [UOP_W-1:0] uop_last,
    output logic             overflow_ev,
    output logic             underflow_ev
);
    import uop_pkg::*;

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [UOP_W:0]   mem_q [DEPTH];
    logic [UOP_W:0]   mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [UOP_W-1:0] uop_last_q, uop_last_d;
    logic [UOP_W:0]   head;
    logic             do_pop;
    logic             do_push;

    assign valid = (count_q != '0);
    assign full  = (count_q == FULL_CNT);
    assign head  = mem_q[rd_ptr_q];

    assign uop_next    = valid ? head[UOP_W-1:0] : NOP_UOP;
    assign uop_is_last = valid & head[UOP_W];
    assign uop_last    = uop_last_q;

    // A full queue still accepts a push when the same stream pops this cycle.
    assign do_pop  = pop_req & valid & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    assign overflow_ev  = push & ~flush & ~do_push;
    assign underflow_ev = pop_req & ~valid & ~flush;

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        uop_last_d = uop_last_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            uop_last_d = NOP_UOP;
        end else begin
            if (do_pop) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                uop_last_d = head[UOP_W-1:0];
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = {push_last, push_uop};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            uop_last_q <= NOP_UOP;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            uop_last_q <= uop_last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uop_dual_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uop_dual_queue
// Desc   : Two micro-op stream FIFOs feeding the dual-stream scheduler.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module uop_dual_queue #(
    parameter int               DEPTH   = 4,
    parameter int               UOP_W   = uop_pkg::UOP_W,
    parameter logic [UOP_W-1:0] NOP_UOP = uop_pkg::NOP_UOP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_a,
    input  logic [UOP_W-1:0] push_uop_a,
    input  logic             push_last_a,
    output logic             full_a,
    input  logic             push_b,
    input  logic [UOP_W-1:0] push_uop_b,
    input  logic             push_last_b,
    output logic             full_b,
    input  logic             issue_en,
    input  logic             issue_sel,
    output logic [UOP_W-1:0] uop_next_a,
    output logic             uop_is_last_a,
    output logic             is_a_valid,
    output logic [UOP_W-1:0] uop_last_a,
    output logic [UOP_W-1:0] uop_next_b,
    output logic             uop_is_last_b,
    output logic             is_b_valid,
    output logic [UOP_W-1:0] uop_last_b,
    output logic             overflow,
    output logic             underflow
);
    import uop_pkg::*;

    logic pop_req_a, pop_req_b;
    logic ovf_a, ovf_b, udf_a, udf_b;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // issue_sel is a one-hot choice, so at most one stream is ever asked to pop.
    assign pop_req_a = issue_en & ~issue_sel;
    assign pop_req_b = issue_en &  issue_sel;

    uop_fifo #(.DEPTH(DEPTH), .UOP_W(UOP_W), .NOP_UOP(NOP_UOP)) u_fifo_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .push         (push_a),
        .push_uop     (push_uop_a),
        .push_last    (push_last_a),
        .pop_req      (pop_req_a),
        .full         (full_a),
        .valid        (is_a_valid),
        .uop_next     (uop_next_a),
        .uop_is_last  (uop_is_last_a),
        .uop_last     (uop_last_a),
        .overflow_ev  (ovf_a),
        .underflow_ev (udf_a)
    );

    uop_fifo #(.DEPTH(DEPTH), .UOP_W(UOP_W), .NOP_UOP(NOP_UOP)) u_fifo_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .push         (push_b),
        .push_uop     (push_uop_b),
        .push_last    (push_last_b),
        .pop_req      (pop_req_b),
        .full         (full_b),
        .valid        (is_b_valid),
        .uop_next     (uop_next_b),
        .uop_is_last  (uop_is_last_b),
        .uop_last     (uop_last_b),
        .overflow_ev  (ovf_b),
        .underflow_ev (udf_b)
    );

    // Error flags are sticky until reset; flush deliberately leaves them alone.
    always_comb begin
        overflow_d  = overflow_q  | ovf_a | ovf_b;
        underflow_d = underflow_q | udf_a | udf_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uop_dual_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_uop_dual_queue
// Desc   : Directed self-checking bench for uop_dual_queue.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_uop_dual_queue;

    localparam logic [19:0] NOP = 20'h00F00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        push_a = 1'b0, push_last_a = 1'b0;
    logic [19:0] push_uop_a = '0;
    logic        push_b = 1'b0, push_last_b = 1'b0;
    logic [19:0] push_uop_b = '0;
    logic        issue_en = 1'b0, issue_sel = 1'b0;
    logic        full_a, full_b;
    logic [19:0] uop_next_a, uop_last_a, uop_next_b, uop_last_b;
    logic        uop_is_last_a, uop_is_last_b, is_a_valid, is_b_valid;
    logic        overflow, underflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uop_dual_queue #(.DEPTH(4), .UOP_W(20), .NOP_UOP(20'h00F00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .push_a        (push_a),
        .push_uop_a    (push_uop_a),
        .push_last_a   (push_last_a),
        .full_a        (full_a),
        .push_b        (push_b),
        .push_uop_b    (push_uop_b),
        .push_last_b   (push_last_b),
        .full_b        (full_b),
        .issue_en      (issue_en),
        .issue_sel     (issue_sel),
        .uop_next_a    (uop_next_a),
        .uop_is_last_a (uop_is_last_a),
        .is_a_valid    (is_a_valid),
        .uop_last_a    (uop_last_a),
        .uop_next_b    (uop_next_b),
        .uop_is_last_b (uop_is_last_b),
        .is_b_valid    (is_b_valid),
        .uop_last_b    (uop_last_b),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [19:0] exp_b [4];
        logic [19:0] v;
        exp_b = '{20'h0B002, 20'h0B003, 20'h0B004, 20'h0B006};

        // Reset and idle
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_a_valid",  32'(is_a_valid), 32'd0);
        check("rst_b_valid",  32'(is_b_valid), 32'd0);
        check("rst_next_a",   32'(uop_next_a), 32'(NOP));
        check("rst_last_b",   32'(uop_last_b), 32'(NOP));
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_full_b",   32'(full_b),     32'd0);

        // Two entries through A, then issue both
        push_a = 1'b1; push_uop_a = 20'h02101; push_last_a = 1'b0;
        step();
        check("a_head0",      32'(uop_next_a),    32'h02101);
        check("a_head0_last", 32'(uop_is_last_a), 32'd0);
        push_uop_a = 20'h03202; push_last_a = 1'b1;
        step();
        push_a = 1'b0; push_last_a = 1'b0;
        issue_en = 1'b1; issue_sel = 1'b0;
        step();
        check("a_last0",      32'(uop_last_a),    32'h02101);
        check("a_head1",      32'(uop_next_a),    32'h03202);
        check("a_head1_last", 32'(uop_is_last_a), 32'd1);
        step();
        issue_en = 1'b0;
        check("a_last1",      32'(uop_last_a), 32'h03202);
        check("a_empty",      32'(is_a_valid), 32'd0);
        check("a_empty_next", 32'(uop_next_a), 32'(NOP));

        // Fill B, overflow, then push-with-pop on full
        for (int i = 1; i <= 4; i++) begin
            push_b = 1'b1; push_uop_b = 20'h0B000 + 20'(i);
            step();
        end
        check("b_full",    32'(full_b),   32'd1);
        check("b_no_ovf",  32'(overflow), 32'd0);
        push_uop_b = 20'h0B005;
        step();
        check("b_ovf",       32'(overflow),   32'd1);
        check("b_full_ovf",  32'(full_b),     32'd1);
        check("b_head_keep", 32'(uop_next_b), 32'h0B001);
        push_uop_b = 20'h0B006; issue_en = 1'b1; issue_sel = 1'b1;
        step();
        push_b = 1'b0;
        check("b_full_pp", 32'(full_b),     32'd1);
        check("b_last_pp", 32'(uop_last_b), 32'h0B001);
        check("b_head_pp", 32'(uop_next_b), 32'h0B002);
        for (int k = 0; k < 4; k++) begin
            step();
            check("b_drain", 32'(uop_last_b), 32'(exp_b[k]));
        end
        issue_en = 1'b0;
        check("b_empty", 32'(is_b_valid), 32'd0);

        // Pointer wrap on A with interleaved pops
        for (int i = 1; i <= 3; i++) begin
            push_a = 1'b1; push_uop_a = 20'h0A000 + 20'(i);
            step();
        end
        for (int i = 4; i <= 6; i++) begin
            push_a = 1'b1; push_uop_a = 20'h0A000 + 20'(i);
            issue_en = 1'b1; issue_sel = 1'b0;
            step();
            v = 20'h0A000 + 20'(i - 3);
            check("wrap_pp", 32'(uop_last_a), 32'(v));
        end
        push_a = 1'b0;
        for (int k = 4; k <= 6; k++) begin
            step();
            v = 20'h0A000 + 20'(k);
            check("wrap_drain", 32'(uop_last_a), 32'(v));
        end
        issue_en = 1'b0;
        check("wrap_empty", 32'(is_a_valid), 32'd0);
        check("no_udf_yet", 32'(underflow),  32'd0);

        // Clear last-issued registers, then underflow on B
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_last_b", 32'(uop_last_b), 32'(NOP));
        push_a = 1'b1; push_uop_a = 20'h00007;
        step();
        push_a = 1'b0;
        issue_en = 1'b1; issue_sel = 1'b1;
        step();
        issue_en = 1'b0;
        check("udf_flag",   32'(underflow),  32'd1);
        check("udf_a_val",  32'(is_a_valid), 32'd1);
        check("udf_a_head", 32'(uop_next_a), 32'h00007);
        check("udf_last_b", 32'(uop_last_b), 32'(NOP));
        check("udf_last_a", 32'(uop_last_a), 32'(NOP));

        // Flush dominating push and pop
        issue_en = 1'b1; issue_sel = 1'b0;
        step();
        issue_en = 1'b0;
        check("pre_flush_last_a", 32'(uop_last_a), 32'h00007);
        push_a = 1'b1; push_uop_a = 20'h00008;
        push_b = 1'b1; push_uop_b = 20'h0B00F;
        step();
        push_b = 1'b0;
        flush = 1'b1; push_uop_a = 20'h0000A; issue_en = 1'b1; issue_sel = 1'b0;
        step();
        flush = 1'b0; push_a = 1'b0; issue_en = 1'b0;
        check("fl_a_valid", 32'(is_a_valid), 32'd0);
        check("fl_b_valid", 32'(is_b_valid), 32'd0);
        check("fl_last_a",  32'(uop_last_a), 32'(NOP));
        check("fl_last_b",  32'(uop_last_b), 32'(NOP));
        check("fl_ovf",     32'(overflow),   32'd1);
        check("fl_udf",     32'(underflow),  32'd1);

        // Asynchronous reset mid-burst
        push_a = 1'b1; push_uop_a = 20'h01111;
        step();
        push_uop_a = 20'h02222; issue_en = 1'b1; issue_sel = 1'b0;
        step();
        check("burst_last_a", 32'(uop_last_a), 32'h01111);
        #2 rst_n = 1'b0;
        #1;
        check("arst_a_valid", 32'(is_a_valid), 32'd0);
        check("arst_next_a",  32'(uop_next_a), 32'(NOP));
        check("arst_last_a",  32'(uop_last_a), 32'(NOP));
        check("arst_ovf",     32'(overflow),   32'd0);
        check("arst_udf",     32'(underflow),  32'd0);
        push_a = 1'b0; issue_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_next_a", 32'(uop_next_a), 32'(NOP));
        check("post_rst_full_b", 32'(full_b),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
